// File: rtl/ttl_74161_chain.sv
// Cascaded 74161/74163-style 4-bit synchronous counters on a single system clock.
// CE marks the emulated board-clock edge; RCO/TC are combinational carry-lookahead outputs.
module ttl_74161_chain #(
    parameter int                 CHIPS       = 2,
    parameter bit                 SYNC_CLEAR  = 1'b0,
    parameter logic [4*CHIPS-1:0] RESET_VALUE = '0
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 CE,
    input  logic                 Clear_bar,
    input  logic                 Load_bar,
    input  logic                 ENP,
    input  logic                 ENT,
    input  logic [4*CHIPS-1:0]   D,
    output logic [4*CHIPS-1:0]   Q,
    output logic [CHIPS-1:0]     RCO,
    output logic                 TC
);

    logic [4*CHIPS-1:0] q_next;
    logic [CHIPS-1:0]   ent_chip;
    logic               carry;
    logic               clear_now;

    // Carry chain is built as a running AND so each chip sees the pre-edge RCO of the one below.
    always_comb begin
        ent_chip = '0;
        RCO      = '0;
        carry    = ENT;
        for (int i = 0; i < CHIPS; i++) begin
            ent_chip[i] = carry;
            carry       = carry & (Q[4*i +: 4] == 4'hF);
            RCO[i]      = carry;
        end
    end

    assign TC        = RCO[CHIPS-1];
    assign clear_now = !Clear_bar && (!SYNC_CLEAR || CE);

    always_comb begin
        q_next = Q;
        if (clear_now) begin
            q_next = '0;
        end else if (CE && !Load_bar) begin
            q_next = D;
        end else if (CE && ENP) begin
            for (int i = 0; i < CHIPS; i++) begin
                if (ent_chip[i]) begin
                    q_next[4*i +: 4] = Q[4*i +: 4] + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            Q <= RESET_VALUE;
        end else begin
            Q <= q_next;
        end
    end

endmodule

// File: tb/tb_ttl_74161_chain.sv
// Bench for ttl_74161_chain: one 74161-mode and one 74163-mode instance fed identical stimulus,
// each compared against an arithmetic model of an 8-bit binary counter.
module tb_ttl_74161_chain;

    logic       clk = 1'b0;
    logic       rst, ce, clr_b, ld_b, enp, ent;
    logic [7:0] d;
    logic [7:0] q0, q1;
    logic [1:0] rco0, rco1;
    logic       tc0, tc1;
    logic [7:0] m0, m1;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    ttl_74161_chain #(.CHIPS(2), .SYNC_CLEAR(1'b0), .RESET_VALUE(8'h00)) dut0 (
        .Clk(clk), .Reset(rst), .CE(ce), .Clear_bar(clr_b), .Load_bar(ld_b),
        .ENP(enp), .ENT(ent), .D(d), .Q(q0), .RCO(rco0), .TC(tc0)
    );

    ttl_74161_chain #(.CHIPS(2), .SYNC_CLEAR(1'b1), .RESET_VALUE(8'h00)) dut1 (
        .Clk(clk), .Reset(rst), .CE(ce), .Clear_bar(clr_b), .Load_bar(ld_b),
        .ENP(enp), .ENT(ent), .D(d), .Q(q1), .RCO(rco1), .TC(tc1)
    );

    function automatic logic [7:0] ref_next(input logic [7:0] q, input bit sync);
        if (rst) return 8'h00;
        if (!clr_b && (!sync || ce)) return 8'h00;
        if (!ce) return q;
        if (!ld_b) return d;
        if (enp && ent) return 8'((int'(q) + 1) % 256);
        return q;
    endfunction

    // Chip i carries when ENT is high and the low 4*(i+1) bits of the value are all ones.
    function automatic logic [1:0] ref_rco(input logic [7:0] q, input logic e);
        logic [1:0] r;
        int span;
        r = 2'b00;
        for (int i = 0; i < 2; i++) begin
            span = 1 << (4 * (i + 1));
            r[i] = e && ((int'(q) % span) == span - 1);
        end
        return r;
    endfunction

    task automatic tick();
        logic [7:0] n0, n1;
        n0 = ref_next(m0, 1'b0);
        n1 = ref_next(m1, 1'b1);
        @(posedge clk);
        #1;
        m0 = n0;
        m1 = n1;
    endtask

    task automatic do_load(input logic [7:0] v);
        ce = 1'b1; ld_b = 1'b0; d = v;
        tick();
        ld_b = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; ce = 1'b0; clr_b = 1'b1; ld_b = 1'b1; enp = 1'b0; ent = 1'b0; d = 8'h00;
        m0 = 8'h00; m1 = 8'h00;
        #2;
        checks++;
        if (q0 !== 8'h00 || q1 !== 8'h00) begin
            errors++; $display("FAIL reset_q: got %h/%h expected 00", q0, q1);
        end
        checks++;
        if (rco0 !== 2'b00 || tc0 !== 1'b0) begin
            errors++; $display("FAIL reset_rco: got %b/%b expected 00/0", rco0, tc0);
        end
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (q0 !== 8'h00) begin
            errors++; $display("FAIL reset_release: got %h expected 00", q0);
        end
    endtask

    task automatic test_count();
        do_load(8'h30);
        ce = 1'b1; enp = 1'b1; ent = 1'b1;
        repeat (7) tick();
        checks++;
        if (q0 !== 8'h37) begin
            errors++; $display("FAIL count_to_37: got %h expected 37", q0);
        end
        rst = 1'b1;
        #1;
        m0 = 8'h00; m1 = 8'h00;
        checks++;
        if (q0 !== 8'h00 || q1 !== 8'h00) begin
            errors++; $display("FAIL async_reset: got %h/%h expected 00", q0, q1);
        end
        rst = 1'b0;
        repeat (20) tick();
        checks++;
        if (q0 !== 8'h14 || q0 !== m0) begin
            errors++; $display("FAIL count_20: got %h expected 14", q0);
        end
    endtask

    task automatic test_cascade();
        enp = 1'b1; ent = 1'b1;
        do_load(8'h0E);
        tick();
        checks++;
        if (q0 !== 8'h0F || rco0 !== 2'b01) begin
            errors++; $display("FAIL cascade_0f: got %h rco %b expected 0f rco 01", q0, rco0);
        end
        tick();
        checks++;
        if (q0 !== 8'h10 || rco0 !== 2'b00) begin
            errors++; $display("FAIL cascade_10: got %h rco %b expected 10 rco 00", q0, rco0);
        end
        do_load(8'hFF);
        checks++;
        if (tc0 !== 1'b1 || rco0 !== 2'b11) begin
            errors++; $display("FAIL tc_at_ff: got tc %b rco %b expected 1 11", tc0, rco0);
        end
        tick();
        checks++;
        if (q0 !== 8'h00 || tc0 !== 1'b0) begin
            errors++; $display("FAIL wrap: got %h tc %b expected 00 tc 0", q0, tc0);
        end
    endtask

    task automatic test_enable();
        do_load(8'h3F);
        enp = 1'b0; ent = 1'b1;
        tick();
        checks++;
        if (q0 !== 8'h3F || rco0 !== 2'b01 || tc0 !== 1'b0) begin
            errors++; $display("FAIL enp_low: got %h rco %b tc %b expected 3f 01 0", q0, rco0, tc0);
        end
        ent = 1'b0;
        #1;
        checks++;
        if (rco0 !== 2'b00) begin
            errors++; $display("FAIL ent_low_rco: got %b expected 00", rco0);
        end
        enp = 1'b1;
        tick();
        checks++;
        if (q0 !== 8'h3F) begin
            errors++; $display("FAIL ent_low_hold: got %h expected 3f", q0);
        end
        ce = 1'b0; ent = 1'b1;
        repeat (10) tick();
        checks++;
        if (q0 !== 8'h3F || q1 !== 8'h3F) begin
            errors++; $display("FAIL ce_low_hold: got %h/%h expected 3f", q0, q1);
        end
    endtask

    task automatic test_load_priority();
        ce = 1'b1; enp = 1'b0; ent = 1'b0;
        ld_b = 1'b0; d = 8'hA5;
        tick();
        checks++;
        if (q0 !== 8'hA5) begin
            errors++; $display("FAIL load_a5: got %h expected a5", q0);
        end
        clr_b = 1'b0;
        tick();
        checks++;
        if (q0 !== 8'h00 || q1 !== 8'h00) begin
            errors++; $display("FAIL clear_over_load: got %h/%h expected 00", q0, q1);
        end
        clr_b = 1'b1; ld_b = 1'b1;
    endtask

    task automatic test_clear_mode();
        enp = 1'b0; ent = 1'b0;
        do_load(8'h5A);
        ce = 1'b0; clr_b = 1'b0;
        tick();
        checks++;
        if (q0 !== 8'h00) begin
            errors++; $display("FAIL async_style_clear: got %h expected 00", q0);
        end
        checks++;
        if (q1 !== 8'h5A) begin
            errors++; $display("FAIL sync_clear_wait1: got %h expected 5a", q1);
        end
        tick();
        checks++;
        if (q1 !== 8'h5A) begin
            errors++; $display("FAIL sync_clear_wait2: got %h expected 5a", q1);
        end
        ce = 1'b1;
        tick();
        checks++;
        if (q1 !== 8'h00) begin
            errors++; $display("FAIL sync_clear_ce: got %h expected 00", q1);
        end
        clr_b = 1'b1;
    endtask

    task automatic test_divide();
        logic [1:0] r;
        logic tog, tc_before;
        int last_tc, last_rise, pulses, rises;
        enp = 1'b1; ent = 1'b1; clr_b = 1'b1;
        do_load(8'hF6);
        tog = 1'b0; last_tc = -1; last_rise = -1; pulses = 0; rises = 0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            r = ref_rco(m0, ent);
            ld_b = !r[1];
            checks++;
            if (tc0 !== r[1]) begin
                errors++; $display("FAIL div_tc cyc %0d: got %b expected %b", cyc, tc0, r[1]);
            end
            if (r[1]) begin
                pulses++;
                if (last_tc >= 0) begin
                    checks++;
                    if (cyc - last_tc != 10) begin
                        errors++; $display("FAIL div_tc_period: got %0d expected 10", cyc - last_tc);
                    end
                end
                last_tc = cyc;
            end
            tc_before = tc0;
            tick();
            if (tc_before === 1'b1) begin
                tog = ~tog;
                if (tog) begin
                    rises++;
                    if (last_rise >= 0) begin
                        checks++;
                        if (cyc - last_rise != 20) begin
                            errors++; $display("FAIL toggle_period: got %0d expected 20", cyc - last_rise);
                        end
                    end
                    last_rise = cyc;
                end
            end
        end
        ld_b = 1'b1;
        checks++;
        if (pulses != 6 || rises != 3) begin
            errors++; $display("FAIL div_pulse_count: got %0d/%0d expected 6/3", pulses, rises);
        end
    endtask

    task automatic test_random();
        logic [1:0] r0, r1;
        for (int n = 0; n < 400; n++) begin
            ce    = ($urandom_range(0, 3) != 0);
            clr_b = ($urandom_range(0, 15) != 0);
            ld_b  = ($urandom_range(0, 7) != 0);
            enp   = ($urandom_range(0, 3) != 0);
            ent   = ($urandom_range(0, 3) != 0);
            d     = ($urandom_range(0, 2) == 0) ? (8'hF0 | 8'($urandom_range(0, 15))) : 8'($urandom);
            if ($urandom_range(0, 40) == 0) begin
                rst = 1'b1;
                #1;
                m0 = 8'h00; m1 = 8'h00;
                rst = 1'b0;
            end
            #1;
            r0 = ref_rco(m0, ent);
            r1 = ref_rco(m1, ent);
            checks++;
            if (rco0 !== r0 || tc0 !== r0[1] || rco1 !== r1 || tc1 !== r1[1]) begin
                errors++;
                $display("FAIL rand_rco n=%0d: got %b/%b expected %b/%b", n, rco0, rco1, r0, r1);
            end
            tick();
            checks++;
            if (q0 !== m0 || q1 !== m1) begin
                errors++;
                $display("FAIL rand_q n=%0d: got %h/%h expected %h/%h", n, q0, q1, m0, m1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_count();
        test_cascade();
        test_enable();
        test_load_priority();
        test_clear_mode();
        test_divide();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
